// File: rtl/seg7_scan_driver.sv
// Scanned common-anode seven-segment driver with double-buffered frame commit,
// per-slot anti-ghosting blanking and per-digit blinking.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 9,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7*NUM_DIGITS-1:0] frame_in,
  input  logic                    frame_load,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic                    frame_busy,
  output logic                    frame_ack,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   dig_n
);

  localparam int FW = 7 * NUM_DIGITS;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_off_q, blink_off_d;
  logic [FW-1:0]         pend_q, pend_d;
  logic [FW-1:0]         disp_q, disp_d;
  logic                  busy_q, busy_d;
  logic                  ack_q, ack_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0] dig_n_q, dig_n_d;

  logic       tick, boundary;
  logic [6:0] digit_seg;

  always_comb begin
    tick     = (cnt_q == CW'(SCAN_DIV - 1));
    boundary = tick && (idx_q == IW'(NUM_DIGITS - 1));

    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (boundary) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // A load landing on the boundary clock is committed straight through.
    pend_d = pend_q;
    busy_d = busy_q;
    disp_d = disp_q;
    ack_d  = 1'b0;
    if (frame_load) begin
      pend_d = frame_in;
      busy_d = 1'b1;
    end
    if (boundary && (busy_q || frame_load)) begin
      disp_d = frame_load ? frame_in : pend_q;
      busy_d = 1'b0;
      ack_d  = 1'b1;
    end

    digit_seg = disp_q[int'(idx_q) * 7 +: 7];
    seg_n_d   = 7'h7F;
    dig_n_d   = '1;
    if (cnt_q >= CW'(BLANK_CYC)) begin
      dig_n_d = ~(NUM_DIGITS'(1) << idx_q);
      seg_n_d = (blink_off_q && blink_mask[idx_q]) ? 7'h7F : ~digit_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      pend_q      <= '0;
      disp_q      <= '0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      seg_n_q     <= 7'h7F;
      dig_n_q     <= '1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      pend_q      <= pend_d;
      disp_q      <= disp_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      seg_n_q     <= seg_n_d;
      dig_n_q     <= dig_n_d;
    end
  end

  assign frame_busy = busy_q;
  assign frame_ack  = ack_q;
  assign seg_n      = seg_n_q;
  assign dig_n      = dig_n_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a short scan (4 clk/slot, 36 clk/frame,
// blink half-period 2 frames); cyc counts clock edges since reset release.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [62:0] frame_in;
  logic        frame_load;
  logic [8:0]  blink_mask;
  logic        frame_busy, frame_ack;
  logic [6:0]  seg_n;
  logic [8:0]  dig_n;

  int cyc, checks, errors, ack_cnt;
  logic [62:0] f;

  seg7_scan_driver #(.NUM_DIGITS(9), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .frame_in(frame_in), .frame_load(frame_load),
    .blink_mask(blink_mask), .frame_busy(frame_busy), .frame_ack(frame_ack),
    .seg_n(seg_n), .dig_n(dig_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (frame_ack === 1'b1) ack_cnt++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_load = 1'b1; frame_in = '1; blink_mask = '1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks += 4;
      if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h exp 7f", seg_n); end
      if (dig_n !== 9'h1FF) begin errors++; $display("FAIL reset_dig got %h exp 1ff", dig_n); end
      if (frame_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", frame_busy); end
      if (frame_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", frame_ack); end
    end
    reset = 1'b0; frame_load = 1'b0; blink_mask = '0; cyc = 0; ack_cnt = 0;
  endtask

  task automatic test_first_load();
    f = '0; f[6:0] = 7'h3F; f[62:56] = 7'h06;
    frame_in = f; frame_load = 1'b1; tick(); frame_load = 1'b0;
    checks += 2;
    if (frame_busy !== 1'b1) begin errors++; $display("FAIL load_busy got %b exp 1", frame_busy); end
    if (frame_ack !== 1'b0) begin errors++; $display("FAIL load_noack got %b exp 0", frame_ack); end
    run_to(3); checks += 2;
    if (dig_n !== 9'h1FE) begin errors++; $display("FAIL old_d0_dig got %h exp 1fe", dig_n); end
    if (seg_n !== 7'h7F) begin errors++; $display("FAIL old_d0_seg got %h exp 7f", seg_n); end
    run_to(35); checks += 2;
    if (frame_busy !== 1'b1) begin errors++; $display("FAIL pre_commit_busy got %b exp 1", frame_busy); end
    if (frame_ack !== 1'b0) begin errors++; $display("FAIL pre_commit_ack got %b exp 0", frame_ack); end
    run_to(36); checks += 2;
    if (frame_ack !== 1'b1) begin errors++; $display("FAIL commit_ack got %b exp 1", frame_ack); end
    if (frame_busy !== 1'b0) begin errors++; $display("FAIL commit_busy got %b exp 0", frame_busy); end
    run_to(37); checks += 3;
    if (frame_ack !== 1'b0) begin errors++; $display("FAIL ack_width got %b exp 0", frame_ack); end
    if (dig_n !== 9'h1FF) begin errors++; $display("FAIL slot_blank_dig got %h exp 1ff", dig_n); end
    if (seg_n !== 7'h7F) begin errors++; $display("FAIL slot_blank_seg got %h exp 7f", seg_n); end
    run_to(38); checks += 2;
    if (dig_n !== 9'h1FE) begin errors++; $display("FAIL new_d0_dig got %h exp 1fe", dig_n); end
    if (seg_n !== 7'h40) begin errors++; $display("FAIL new_d0_seg got %h exp 40", seg_n); end
    run_to(70); checks += 3;
    if (dig_n !== 9'h0FF) begin errors++; $display("FAIL new_d8_dig got %h exp 0ff", dig_n); end
    if (seg_n !== 7'h79) begin errors++; $display("FAIL new_d8_seg got %h exp 79", seg_n); end
    if (ack_cnt !== 1) begin errors++; $display("FAIL first_ack_count got %0d exp 1", ack_cnt); end
  endtask

  task automatic test_mid_frame_load();
    ack_cnt = 0;
    run_to(88);
    f = '0; f[6:0] = 7'h07; f[41:35] = 7'h6D; f[62:56] = 7'h66;
    frame_in = f; frame_load = 1'b1; tick(); frame_load = 1'b0;
    checks += 1;
    if (frame_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", frame_busy); end
    run_to(94); checks += 2;
    if (dig_n !== 9'h1DF) begin errors++; $display("FAIL mid_old_d5_dig got %h exp 1df", dig_n); end
    if (seg_n !== 7'h7F) begin errors++; $display("FAIL mid_old_d5_seg got %h exp 7f", seg_n); end
    run_to(106); checks += 1;
    if (seg_n !== 7'h79) begin errors++; $display("FAIL mid_old_d8_seg got %h exp 79", seg_n); end
    run_to(107); checks += 1;
    if (frame_ack !== 1'b0) begin errors++; $display("FAIL mid_early_ack got %b exp 0", frame_ack); end
    run_to(108); checks += 1;
    if (frame_ack !== 1'b1) begin errors++; $display("FAIL mid_commit_ack got %b exp 1", frame_ack); end
    run_to(130); checks += 2;
    if (dig_n !== 9'h1DF) begin errors++; $display("FAIL mid_new_d5_dig got %h exp 1df", dig_n); end
    if (seg_n !== 7'h12) begin errors++; $display("FAIL mid_new_d5_seg got %h exp 12", seg_n); end
    run_to(142); checks += 2;
    if (seg_n !== 7'h19) begin errors++; $display("FAIL mid_new_d8_seg got %h exp 19", seg_n); end
    if (ack_cnt !== 1) begin errors++; $display("FAIL mid_ack_count got %0d exp 1", ack_cnt); end
  endtask

  task automatic test_back_to_back();
    ack_cnt = 0;
    run_to(150);
    f = '0; f[6:0] = 7'h01;
    frame_in = f; frame_load = 1'b1; tick(); frame_load = 1'b0;
    run_to(160);
    f = '0; f[6:0] = 7'h7E;
    frame_in = f; frame_load = 1'b1; tick(); frame_load = 1'b0;
    run_to(179); checks += 2;
    if (frame_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", frame_busy); end
    if (frame_ack !== 1'b0) begin errors++; $display("FAIL b2b_early_ack got %b exp 0", frame_ack); end
    run_to(180); checks += 1;
    if (frame_ack !== 1'b1) begin errors++; $display("FAIL b2b_commit_ack got %b exp 1", frame_ack); end
    run_to(182); checks += 2;
    if (dig_n !== 9'h1FE) begin errors++; $display("FAIL b2b_d0_dig got %h exp 1fe", dig_n); end
    if (seg_n !== 7'h01) begin errors++; $display("FAIL b2b_last_wins got %h exp 01", seg_n); end
    run_to(214); checks += 1;
    if (ack_cnt !== 1) begin errors++; $display("FAIL b2b_ack_count got %0d exp 1", ack_cnt); end
  endtask

  task automatic test_load_at_boundary();
    ack_cnt = 0;
    run_to(215); checks += 1;
    if (frame_busy !== 1'b0) begin errors++; $display("FAIL bnd_idle_busy got %b exp 0", frame_busy); end
    f = '0; f[6:0] = 7'h3F; f[20:14] = 7'h5B; f[27:21] = 7'h4F;
    frame_in = f; frame_load = 1'b1; blink_mask = 9'h008; tick(); frame_load = 1'b0;
    checks += 2;
    if (frame_ack !== 1'b1) begin errors++; $display("FAIL bnd_ack got %b exp 1", frame_ack); end
    if (frame_busy !== 1'b0) begin errors++; $display("FAIL bnd_busy got %b exp 0", frame_busy); end
    run_to(218); checks += 1;
    if (seg_n !== 7'h40) begin errors++; $display("FAIL bnd_d0_seg got %h exp 40", seg_n); end
  endtask

  task automatic test_blink();
    run_to(226); checks += 2;
    if (dig_n !== 9'h1FB) begin errors++; $display("FAIL blink_d2_dig got %h exp 1fb", dig_n); end
    if (seg_n !== 7'h24) begin errors++; $display("FAIL blink_d2_unmasked got %h exp 24", seg_n); end
    run_to(229); checks += 1;
    if (dig_n !== 9'h1FF) begin errors++; $display("FAIL blink_slot_blank got %h exp 1ff", dig_n); end
    run_to(230); checks += 2;
    if (dig_n !== 9'h1F7) begin errors++; $display("FAIL blink_off_dig got %h exp 1f7", dig_n); end
    if (seg_n !== 7'h7F) begin errors++; $display("FAIL blink_off_f6 got %h exp 7f", seg_n); end
    run_to(262); checks += 1;
    if (seg_n !== 7'h24) begin errors++; $display("FAIL blink_d2_f7 got %h exp 24", seg_n); end
    run_to(266); checks += 1;
    if (seg_n !== 7'h7F) begin errors++; $display("FAIL blink_off_f7 got %h exp 7f", seg_n); end
    run_to(302); checks += 2;
    if (dig_n !== 9'h1F7) begin errors++; $display("FAIL blink_on_dig got %h exp 1f7", dig_n); end
    if (seg_n !== 7'h30) begin errors++; $display("FAIL blink_on_f8 got %h exp 30", seg_n); end
    run_to(338); checks += 1;
    if (seg_n !== 7'h30) begin errors++; $display("FAIL blink_on_f9 got %h exp 30", seg_n); end
    run_to(374); checks += 1;
    if (seg_n !== 7'h7F) begin errors++; $display("FAIL blink_off_f10 got %h exp 7f", seg_n); end
  endtask

  task automatic test_reset_mid_pending();
    ack_cnt = 0; blink_mask = '0;
    run_to(380);
    frame_in = '1; frame_load = 1'b1; tick(); frame_load = 1'b0;
    checks += 1;
    if (frame_busy !== 1'b1) begin errors++; $display("FAIL rst_pend_busy got %b exp 1", frame_busy); end
    reset = 1'b1; tick(); tick();
    checks += 3;
    if (frame_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", frame_busy); end
    if (seg_n !== 7'h7F) begin errors++; $display("FAIL rst_mid_seg got %h exp 7f", seg_n); end
    if (dig_n !== 9'h1FF) begin errors++; $display("FAIL rst_mid_dig got %h exp 1ff", dig_n); end
    reset = 1'b0; cyc = 0;
    run_to(3); checks += 2;
    if (dig_n !== 9'h1FE) begin errors++; $display("FAIL rst_d0_dig got %h exp 1fe", dig_n); end
    if (seg_n !== 7'h7F) begin errors++; $display("FAIL rst_d0_seg got %h exp 7f", seg_n); end
    run_to(38); checks += 1;
    if (seg_n !== 7'h7F) begin errors++; $display("FAIL rst_disp_cleared got %h exp 7f", seg_n); end
    run_to(40); checks += 2;
    if (frame_busy !== 1'b0) begin errors++; $display("FAIL rst_after_busy got %b exp 0", frame_busy); end
    if (ack_cnt !== 0) begin errors++; $display("FAIL rst_no_ack got %0d exp 0", ack_cnt); end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; ack_cnt = 0;
    reset = 1'b1; frame_load = 1'b0; frame_in = '0; blink_mask = '0;
    @(negedge clk);
    test_reset();
    test_first_load();
    test_mid_frame_load();
    test_back_to_back();
    test_load_at_boundary();
    test_blink();
    test_reset_mid_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
